ctrl_seq16: RTL and testbench
=============================

CTRL_SEQ16 -- requirements
Module: ctrl_seq16

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: RST_N  in  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-003 SHALL have ports: OP  in  25  one-hot decoded instruction from InstrDec16; bits 0..24 = LHI, LLI, LDR_imm, LDR_reg, STR_imm, STR_reg, ADD, ADC, SUB, SBB, CMP, ADDI, SUBI, MOV, BCC, BCS, BNE, BEQ, BAL, JMP, JAL_lbl, JAL_reg, JR, OutR, HLT.
REQ-004 SHALL have ports: FLAG_C, FLAG_Z  in  1 each  registered carry/zero flags.
REQ-005 SHALL have ports: MEM_RDY  in  1  memory ready for the current MEM_RD/MEM_WR request.
REQ-006 SHALL have ports: MEM_RD, MEM_WR  out  1 each  memory request, held until MEM_RDY.
REQ-007 SHALL have ports: IR_LD, PC_LD, REG_WE, FLAG_WE, OUT_LD  out  1 each  one-cycle load strobes.
REQ-008 SHALL have ports: ALU_OP  out  3; PC_SEL  out  2; WB_SEL  out  2; ADDR_SEL  out  1 (0=PC, 1=ALU result).
REQ-009 SHALL have ports: HALTED  out  1; ILLEGAL  out  1  one-cycle pulse; STATE  out  3  current state, for debug.

Function
REQ-010 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT; the outputs are decoded from the state, OP, flags and MEM_RDY.
REQ-011 FETCH: SHALL assert MEM_RD with ADDR_SEL=0; while MEM_RDY=0, SHALL stay in FETCH with all strobes 0; on MEM_RDY=1, SHALL pulse IR_LD and PC_LD with PC_SEL=00 (PC+1), then go to DECODE.
REQ-012 DECODE: SHALL be one settle cycle with no strobes; then go to EXEC.
REQ-013 EXEC, illegal OP (zero bits set or more than one bit set): SHALL pulse ILLEGAL and go to FETCH with no other strobe.
REQ-014 EXEC, ALU ops: SHALL set ALU_OP = ADD 000, ADC 001, SUB 010, SBB 011, ADDI 000, SUBI 010, MOV 100 (pass B); then go to WB with WB_SEL=00.
REQ-015 EXEC, CMP: SHALL set ALU_OP=010 and pulse FLAG_WE with REG_WE=0, then go to FETCH.
REQ-016 EXEC, LHI/LLI: SHALL set ALU_OP=100, then go to WB with WB_SEL=11 (byte merge).
REQ-017 EXEC, LDR/STR: SHALL set ALU_OP=000 (address add), then go to MEM.
REQ-018 EXEC, branches: taken when BCC: C=0, BCS: C=1, BNE: Z=0, BEQ: Z=1, BAL: always; taken SHALL pulse PC_LD with PC_SEL=01 (PC+sext imm8); not taken SHALL pulse nothing; then go to FETCH.
REQ-019 EXEC, JMP: SHALL pulse PC_LD with PC_SEL=10, then go to FETCH.
REQ-020 EXEC, JR: SHALL pulse PC_LD with PC_SEL=11 (register), then go to FETCH.
REQ-021 EXEC, JAL_lbl/JAL_reg: SHALL go to WB; in WB, SHALL write the link (REG_WE, WB_SEL=10, old PC) in the same cycle as PC_LD with PC_SEL=10 or 11 respectively.
REQ-022 EXEC, OutR: SHALL pulse OUT_LD, then go to FETCH.
REQ-023 EXEC, HLT: SHALL go to HALT.
REQ-024 MEM: SHALL assert MEM_RD (LDR) or MEM_WR (STR) with ADDR_SEL=1 until MEM_RDY=1; on ready, STR SHALL go to FETCH and LDR SHALL go to WB with WB_SEL=01.
REQ-025 WB: SHALL pulse REG_WE; ADD/ADC/SUB/SBB/ADDI/SUBI SHALL also pulse FLAG_WE; then go to FETCH.
REQ-026 HALT: SHALL hold HALTED=1 with all strobes 0, exited only by reset.
REQ-027 Minimum latencies with MEM_RDY=1: ALU op 4 cycles, LDR 5, STR 4, branch/jump/CMP/OutR 3.
REQ-028 MEM_RD and MEM_WR SHALL never be asserted in the same cycle.

Reset
REQ-029 RST_N=0 at an edge SHALL force FETCH and clear ILLEGAL/HALTED from any state, including mid MEM wait; while RST_N=0, all strobes, MEM_RD and MEM_WR SHALL be 0.
REQ-030 After RST_N is released, the first MEM_RD SHALL occur in the first cycle with RST_N=1.

Structure
REQ-031 A shared package cpu16_pkg SHALL hold the OP bit indices, the state encoding, and the ALU_OP/PC_SEL/WB_SEL constants.
REQ-032 Branch-condition evaluation SHALL be one sub-module br_cond16 (inputs OP[18:14], FLAG_C, FLAG_Z; output taken).

Verification
REQ-033 ADD (OP=0x40), MEM_RDY=1 -> IR_LD cycle 1, REG_WE and FLAG_WE cycle 4, ALU_OP=000, back in FETCH cycle 5.
REQ-034 LDR_imm (OP=0x4), MEM_RDY low 3 cycles in MEM -> MEM_RD held 3 cycles with ADDR_SEL=1, then REG_WE with WB_SEL=01.
REQ-035 BEQ (OP=0x20000), Z=1 -> PC_LD with PC_SEL=01 in EXEC; with Z=0 -> no PC_LD in EXEC.
REQ-036 JAL_reg (OP=0x200000) -> REG_WE, WB_SEL=10, PC_LD and PC_SEL=11 all in the same WB cycle.
REQ-037 OP=0x3 (two bits set) -> ILLEGAL pulse, no REG_WE/PC_LD, next state FETCH.
REQ-038 HLT (OP=0x1000000) -> HALTED=1 persists 10 cycles with no MEM_RD; RST_N low for one edge -> FETCH, HALTED=0.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit CPU control path: one-hot OP bit positions,
// sequencer state codes and the ALU_OP / PC_SEL / WB_SEL select encodings.
package cpu16_pkg;

  localparam int OP_W = 25;

  localparam int OP_LHI     = 0;
  localparam int OP_LLI     = 1;
  localparam int OP_LDR_IMM = 2;
  localparam int OP_LDR_REG = 3;
  localparam int OP_STR_IMM = 4;
  localparam int OP_STR_REG = 5;
  localparam int OP_ADD     = 6;
  localparam int OP_ADC     = 7;
  localparam int OP_SUB     = 8;
  localparam int OP_SBB     = 9;
  localparam int OP_CMP     = 10;
  localparam int OP_ADDI    = 11;
  localparam int OP_SUBI    = 12;
  localparam int OP_MOV     = 13;
  localparam int OP_BCC     = 14;
  localparam int OP_BCS     = 15;
  localparam int OP_BNE     = 16;
  localparam int OP_BEQ     = 17;
  localparam int OP_BAL     = 18;
  localparam int OP_JMP     = 19;
  localparam int OP_JAL_LBL = 20;
  localparam int OP_JAL_REG = 21;
  localparam int OP_JR      = 22;
  localparam int OP_OUTR    = 23;
  localparam int OP_HLT     = 24;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_ADC   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_SBB   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_ABS = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_BYTE = 2'b11;

  // A decoded OP is only meaningful when exactly one bit is set.
  function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < OP_W; i++) begin
      if (op[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage

// File: rtl/br_cond16.sv
// Conditional-branch evaluation from the five branch OP bits (BCC..BAL)
// and the registered carry/zero flags.
module br_cond16 (
  input  logic [4:0] br_op,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       taken
);

  assign taken = (br_op[0] & ~flag_c) |
                 (br_op[1] &  flag_c) |
                 (br_op[2] & ~flag_z) |
                 (br_op[3] &  flag_z) |
                  br_op[4];

endmodule

// File: rtl/ctrl_seq16.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT, with all
// strobes decoded from the current state, OP, flags and MEM_RDY.
module ctrl_seq16
  import cpu16_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OP_W-1:0] OP,
  input  logic            FLAG_C,
  input  logic            FLAG_Z,
  input  logic            MEM_RDY,
  output logic            MEM_RD,
  output logic            MEM_WR,
  output logic            IR_LD,
  output logic            PC_LD,
  output logic            REG_WE,
  output logic            FLAG_WE,
  output logic            OUT_LD,
  output logic [2:0]      ALU_OP,
  output logic [1:0]      PC_SEL,
  output logic [1:0]      WB_SEL,
  output logic            ADDR_SEL,
  output logic            HALTED,
  output logic            ILLEGAL,
  output logic [2:0]      STATE
);

  logic [2:0] state_q, state_d;

  logic       legal, taken;
  logic       is_ldr, is_str, is_alu, is_flag_alu, is_byte, is_br, is_jal;
  logic [2:0] alu_dec;

  logic       mem_rd_c, mem_wr_c, addr_sel_c, ir_ld_c, pc_ld_c;
  logic       reg_we_c, flag_we_c, out_ld_c, illegal_c;
  logic [1:0] pc_sel_c, wb_sel_c;
  logic [2:0] alu_op_c;

  assign legal       = op_is_onehot(OP);
  assign is_ldr      = OP[OP_LDR_IMM] | OP[OP_LDR_REG];
  assign is_str      = OP[OP_STR_IMM] | OP[OP_STR_REG];
  assign is_flag_alu = OP[OP_ADD] | OP[OP_ADC] | OP[OP_SUB] | OP[OP_SBB] |
                       OP[OP_ADDI] | OP[OP_SUBI];
  assign is_alu      = is_flag_alu | OP[OP_MOV];
  assign is_byte     = OP[OP_LHI] | OP[OP_LLI];
  assign is_br       = |OP[OP_BAL:OP_BCC];
  assign is_jal      = OP[OP_JAL_LBL] | OP[OP_JAL_REG];

  br_cond16 u_br_cond (
    .br_op  (OP[OP_BAL:OP_BCC]),
    .flag_c (FLAG_C),
    .flag_z (FLAG_Z),
    .taken  (taken)
  );

  // ALU function is held through MEM/WB so the address/result stay stable.
  always_comb begin
    alu_dec = ALU_ADD;
    if (OP[OP_ADC])                            alu_dec = ALU_ADC;
    else if (OP[OP_SUB] | OP[OP_SUBI] | OP[OP_CMP]) alu_dec = ALU_SUB;
    else if (OP[OP_SBB])                       alu_dec = ALU_SBB;
    else if (OP[OP_MOV] | is_byte)             alu_dec = ALU_PASSB;
  end

  always_comb begin
    state_d    = state_q;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_ld_c    = 1'b0;
    pc_ld_c    = 1'b0;
    reg_we_c   = 1'b0;
    flag_we_c  = 1'b0;
    out_ld_c   = 1'b0;
    illegal_c  = 1'b0;
    pc_sel_c   = PC_INC;
    wb_sel_c   = WB_ALU;
    alu_op_c   = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        mem_rd_c = 1'b1;
        if (MEM_RDY) begin
          ir_ld_c = 1'b1;
          pc_ld_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op_c = alu_dec;
        state_d  = ST_FETCH;
        if (!legal)                illegal_c = 1'b1;
        else if (is_alu | is_byte | is_jal) state_d = ST_WB;
        else if (OP[OP_CMP])       flag_we_c = 1'b1;
        else if (is_ldr | is_str)  state_d = ST_MEM;
        else if (is_br) begin
          pc_ld_c  = taken;
          pc_sel_c = PC_REL;
        end else if (OP[OP_JMP]) begin
          pc_ld_c  = 1'b1;
          pc_sel_c = PC_ABS;
        end else if (OP[OP_JR]) begin
          pc_ld_c  = 1'b1;
          pc_sel_c = PC_REG;
        end else if (OP[OP_OUTR])  out_ld_c = 1'b1;
        else if (OP[OP_HLT])       state_d = ST_HALT;
      end
      ST_MEM: begin
        alu_op_c   = alu_dec;
        addr_sel_c = 1'b1;
        mem_rd_c   = is_ldr;
        mem_wr_c   = ~is_ldr & is_str;
        if (MEM_RDY) state_d = is_ldr ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        alu_op_c = alu_dec;
        reg_we_c = 1'b1;
        state_d  = ST_FETCH;
        if (is_ldr) wb_sel_c = WB_MEM;
        else if (is_jal) begin
          wb_sel_c = WB_LINK;
          pc_ld_c  = 1'b1;
          pc_sel_c = OP[OP_JAL_REG] ? PC_REG : PC_ABS;
        end else if (is_byte) wb_sel_c = WB_BYTE;
        else begin
          wb_sel_c  = WB_ALU;
          flag_we_c = is_flag_alu;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Reset masks every request/strobe combinationally, so nothing leaks while RST_N is low.
  assign MEM_RD   = RST_N & mem_rd_c;
  assign MEM_WR   = RST_N & mem_wr_c;
  assign IR_LD    = RST_N & ir_ld_c;
  assign PC_LD    = RST_N & pc_ld_c;
  assign REG_WE   = RST_N & reg_we_c;
  assign FLAG_WE  = RST_N & flag_we_c;
  assign OUT_LD   = RST_N & out_ld_c;
  assign ILLEGAL  = RST_N & illegal_c;
  assign ADDR_SEL = addr_sel_c;
  assign PC_SEL   = pc_sel_c;
  assign WB_SEL   = wb_sel_c;
  assign ALU_OP   = alu_op_c;
  assign HALTED   = (state_q == ST_HALT);
  assign STATE    = state_q;

endmodule

// File: tb/tb_ctrl_seq16.sv
// Bench for ctrl_seq16: a per-instruction cycle-trace model built from the
// sequencing rules, replayed against the DUT with directed and random OPs.
module tb_ctrl_seq16;
  import cpu16_pkg::ST_FETCH, cpu16_pkg::ST_DECODE, cpu16_pkg::ST_EXEC,
         cpu16_pkg::ST_MEM, cpu16_pkg::ST_WB, cpu16_pkg::ST_HALT;

  logic        CLK = 1'b0;
  logic        RST_N, FLAG_C, FLAG_Z, MEM_RDY;
  logic [24:0] OP;
  logic        MEM_RD, MEM_WR, IR_LD, PC_LD, REG_WE, FLAG_WE, OUT_LD;
  logic [2:0]  ALU_OP, STATE;
  logic [1:0]  PC_SEL, WB_SEL;
  logic        ADDR_SEL, HALTED, ILLEGAL;

  int errors = 0;
  int checks = 0;

  ctrl_seq16 dut (
    .CLK(CLK), .RST_N(RST_N), .OP(OP), .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z),
    .MEM_RDY(MEM_RDY), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IR_LD(IR_LD),
    .PC_LD(PC_LD), .REG_WE(REG_WE), .FLAG_WE(FLAG_WE), .OUT_LD(OUT_LD),
    .ALU_OP(ALU_OP), .PC_SEL(PC_SEL), .WB_SEL(WB_SEL), .ADDR_SEL(ADDR_SEL),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rdy;
    logic [2:0] st;
    logic       mem_rd, mem_wr, addr_sel, ir_ld, pc_ld;
    logic [1:0] pc_sel;
    logic       reg_we, flag_we;
    logic [1:0] wb_sel;
    logic       out_ld, illegal, halted, alu_chk;
    logic [2:0] alu_op;
  } cyc_t;

  cyc_t q[$];

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t r;
    r = '{default: '0};
    r.st  = st;
    r.rdy = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from the sequencing rules.
  task automatic build(input logic [24:0] op, input logic c, input logic z,
                       input int fwait, input int mwait);
    cyc_t r;
    int   k;
    logic [2:0] a;
    for (int i = 0; i < fwait; i++) begin
      r = blank(ST_FETCH); r.rdy = 0; r.mem_rd = 1; q.push_back(r);
    end
    r = blank(ST_FETCH); r.rdy = 1; r.mem_rd = 1; r.ir_ld = 1; r.pc_ld = 1; r.pc_sel = 0;
    q.push_back(r);
    q.push_back(blank(ST_DECODE));
    r = blank(ST_EXEC);
    if ($countones(op) != 1) begin
      r.illegal = 1; q.push_back(r); return;
    end
    k = 0;
    for (int i = 0; i < 25; i++) if (op[i]) k = i;
    case (k)
      6, 7, 8, 9, 11, 12, 13: begin
        case (k)
          7: a = 3'd1;
          8, 12: a = 3'd2;
          9: a = 3'd3;
          13: a = 3'd4;
          default: a = 3'd0;
        endcase
        r.alu_chk = 1; r.alu_op = a; q.push_back(r);
        r = blank(ST_WB); r.reg_we = 1; r.wb_sel = 0; r.flag_we = (k != 13); q.push_back(r);
      end
      10: begin
        r.alu_chk = 1; r.alu_op = 3'd2; r.flag_we = 1; q.push_back(r);
      end
      0, 1: begin
        r.alu_chk = 1; r.alu_op = 3'd4; q.push_back(r);
        r = blank(ST_WB); r.reg_we = 1; r.wb_sel = 3; q.push_back(r);
      end
      2, 3, 4, 5: begin
        r.alu_chk = 1; r.alu_op = 3'd0; q.push_back(r);
        for (int i = 0; i <= mwait; i++) begin
          r = blank(ST_MEM); r.rdy = (i == mwait); r.addr_sel = 1;
          r.mem_rd = (k < 4); r.mem_wr = (k >= 4); q.push_back(r);
        end
        if (k < 4) begin
          r = blank(ST_WB); r.reg_we = 1; r.wb_sel = 1; q.push_back(r);
        end
      end
      14, 15, 16, 17, 18: begin
        r.pc_ld = (k == 14) ? !c : (k == 15) ? c : (k == 16) ? !z : (k == 17) ? z : 1'b1;
        r.pc_sel = 1; q.push_back(r);
      end
      19: begin r.pc_ld = 1; r.pc_sel = 2; q.push_back(r); end
      22: begin r.pc_ld = 1; r.pc_sel = 3; q.push_back(r); end
      20, 21: begin
        q.push_back(r);
        r = blank(ST_WB); r.reg_we = 1; r.wb_sel = 2; r.pc_ld = 1;
        r.pc_sel = (k == 20) ? 2'd2 : 2'd3; q.push_back(r);
      end
      23: begin r.out_ld = 1; q.push_back(r); end
      default: q.push_back(r);
    endcase
  endtask

  // Replays the queued trace: inputs at the falling edge, outputs checked 1 time unit later.
  task automatic run(input string name, input logic [24:0] op, input logic c, input logic z);
    cyc_t r;
    int   cyc = 0;
    string t;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge CLK);
      if (cyc == 0) begin OP = op; FLAG_C = c; FLAG_Z = z; end
      MEM_RDY = r.rdy;
      #1;
      cyc++;
      t = $sformatf("%s c%0d", name, cyc);
      chk({t, " STATE"}, STATE, r.st);
      chk({t, " MEM_RD"}, 3'(MEM_RD), 3'(r.mem_rd));
      chk({t, " MEM_WR"}, 3'(MEM_WR), 3'(r.mem_wr));
      chk({t, " IR_LD"}, 3'(IR_LD), 3'(r.ir_ld));
      chk({t, " PC_LD"}, 3'(PC_LD), 3'(r.pc_ld));
      chk({t, " REG_WE"}, 3'(REG_WE), 3'(r.reg_we));
      chk({t, " FLAG_WE"}, 3'(FLAG_WE), 3'(r.flag_we));
      chk({t, " OUT_LD"}, 3'(OUT_LD), 3'(r.out_ld));
      chk({t, " ILLEGAL"}, 3'(ILLEGAL), 3'(r.illegal));
      chk({t, " HALTED"}, 3'(HALTED), 3'(r.halted));
      if (r.mem_rd | r.mem_wr) chk({t, " ADDR_SEL"}, 3'(ADDR_SEL), 3'(r.addr_sel));
      if (r.pc_ld)   chk({t, " PC_SEL"}, 3'(PC_SEL), 3'(r.pc_sel));
      if (r.reg_we)  chk({t, " WB_SEL"}, 3'(WB_SEL), 3'(r.wb_sel));
      if (r.alu_chk) chk({t, " ALU_OP"}, ALU_OP, r.alu_op);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " strobes"},
        {1'b0, MEM_RD | MEM_WR, IR_LD | PC_LD | REG_WE | FLAG_WE | OUT_LD | ILLEGAL}, 3'd0);
  endtask

  // One reset edge then release; checks reset masking and the immediate fetch.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST_N = 0; MEM_RDY = 1'($urandom_range(0, 1));
    #1 chk_quiet({tag, " during"});
    @(negedge CLK);
    MEM_RDY = 0;
    #1 chk_quiet({tag, " held"});
    chk({tag, " STATE"}, STATE, ST_FETCH);
    chk({tag, " HALTED"}, 3'(HALTED), 3'd0);
    RST_N = 1;
    #1 chk({tag, " first MEM_RD"}, 3'(MEM_RD), 3'd1);
    chk({tag, " ADDR_SEL"}, 3'(ADDR_SEL), 3'd0);
    chk({tag, " no IR_LD"}, 3'(IR_LD), 3'd0);
  endtask

  initial begin
    logic [24:0] rop;
    RST_N = 0; OP = '0; FLAG_C = 0; FLAG_Z = 0; MEM_RDY = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      MEM_RDY = 1'($urandom_range(0, 1));
      #1 chk_quiet($sformatf("reset%0d", i));
    end
    do_reset("rel0");

    build(25'h40, 0, 0, 0, 0);       run("ADD", 25'h40, 0, 0);
    build(25'h4, 0, 0, 0, 3);        run("LDR_imm", 25'h4, 0, 0);
    build(25'h20000, 0, 1, 0, 0);    run("BEQ_z1", 25'h20000, 0, 1);
    build(25'h20000, 1, 0, 0, 0);    run("BEQ_z0", 25'h20000, 1, 0);
    build(25'h200000, 0, 0, 0, 0);   run("JAL_reg", 25'h200000, 0, 0);
    build(25'h3, 0, 0, 0, 0);        run("ILL_two", 25'h3, 0, 0);
    build(25'h0, 0, 0, 1, 0);        run("ILL_zero", 25'h0, 0, 0);
    build(25'h20, 0, 0, 2, 2);       run("STR_reg", 25'h20, 0, 0);
    build(25'h80000, 0, 0, 1, 0);    run("JMP", 25'h80000, 0, 0);
    build(25'h400000, 0, 0, 0, 0);   run("JR", 25'h400000, 0, 0);
    build(25'h400, 0, 0, 0, 0);      run("CMP", 25'h400, 0, 0);
    build(25'h800000, 0, 0, 0, 0);   run("OutR", 25'h800000, 0, 0);
    build(25'h1, 0, 0, 0, 0);        run("LHI", 25'h1, 0, 0);
    build(25'h100000, 0, 0, 0, 0);   run("JAL_lbl", 25'h100000, 0, 0);
    build(25'h2000, 0, 0, 0, 0);     run("MOV", 25'h2000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic rc, rz;
      if ($urandom_range(0, 9) == 0) rop = 25'($urandom());
      else rop = 25'(1) << $urandom_range(0, 23);
      if (rop == 25'h1000000) rop = '0;
      rc = 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1));
      build(rop, rc, rz, $urandom_range(0, 3), $urandom_range(0, 3));
      run($sformatf("rnd%0d op=%0h", n, rop), rop, rc, rz);
    end

    build(25'h8, 0, 0, 0, 5);
    while (q.size() > 5) void'(q.pop_back());
    run("LDR_cut", 25'h8, 0, 0);
    do_reset("rst_mem");

    build(25'h1000000, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc_t h;
      h = blank(ST_HALT); h.halted = 1; q.push_back(h);
    end
    run("HLT", 25'h1000000, 0, 0);
    do_reset("rst_halt");

    build(25'h40, 0, 0, 0, 0);       run("ADD_post", 25'h40, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
